// File: rtl/program_counter16.sv
// -----------------------------------------------------------------------------
// program_counter16
//   Hack CPU program counter with a valid/ready fetch handshake toward the
//   instruction ROM and jump-to-self (end-of-program) halt detection.
//
//   Parameters
//     WIDTH      PC / fetch address width in bits.
//     RESET_VEC  PC value after rst_n or clr.
//
//   Ports
//     clk            system clock, rising edge
//     rst_n          asynchronous active-low reset
//     clr            synchronous restart (Hack "reset" pin), highest priority
//     en_inc         advance to pc+1 on the next accepted fetch
//     load           jump taken; take load_addr on the next accepted fetch
//     load_addr      jump target (Hack A register)
//     fetch_ready    ROM accepts the current pc this cycle
//     pc             current fetch address (registered)
//     pc_valid       pc is a live fetch request (registered state decode)
//     halted         CPU parked in a jump-to-self loop (registered state decode)
//     last_jump_src  pre-jump pc of the most recent taken load
//                    (only when PC_TRACE_EN is defined)
//
//   Build option
//     PC_TRACE_EN    when defined, adds the last_jump_src trace register/port.
// -----------------------------------------------------------------------------
module program_counter16 #(
  parameter int unsigned            WIDTH     = 16,
  parameter logic [WIDTH-1:0]       RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en_inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             halted
`ifdef PC_TRACE_EN
  ,
  output logic [WIDTH-1:0] last_jump_src
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // one dead cycle after reset or clr
    RUN  = 2'd1,  // issuing fetches
    HALT = 2'd2   // parked on jump-to-self
  } pcState_t;

  pcState_t         state;
  pcState_t         stateNext;
  logic [WIDTH-1:0] pcNext;
  logic             fire;
  logic             jumpTaken;

  // Outputs decode straight from flops, so no input reaches them combinationally.
  assign pc_valid = (state == RUN);
  assign halted   = (state == HALT);

  assign fire      = pc_valid && fetch_ready;
  // A load that is accepted this edge, whether it jumps or detects a halt.
  assign jumpTaken = !clr && fire && load;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    if (clr) begin
      pcNext    = RESET_VEC;
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE: stateNext = RUN;
        RUN: begin
          if (fire) begin
            if (load) begin
              // Jumping to the current address is the Hack end-of-program loop.
              if (load_addr == pc) stateNext = HALT;
              else                 pcNext    = load_addr;
            end else if (en_inc) begin
              pcNext = pc + WIDTH'(1);  // wraps silently at the top
            end
          end
        end
        HALT:    stateNext = HALT;
        default: stateNext = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_VEC;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
    end
  end

`ifdef PC_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_jump_src <= '0;
    else if (clr)       last_jump_src <= '0;
    else if (jumpTaken) last_jump_src <= pc;
  end
`else
  // Keeps the otherwise trace-only term referenced in the default build.
  logic unusedJump;
  assign unusedJump = jumpTaken;
`endif

endmodule

// File: tb/tb_program_counter16.sv
// -----------------------------------------------------------------------------
// tb_program_counter16
//   Self-checking bench for program_counter16: directed scenarios followed by
//   randomized traffic, all compared against a behavioural model of the PC.
//   Define PC_TRACE_EN for both files to exercise last_jump_src.
// -----------------------------------------------------------------------------
module tb_program_counter16;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             en_inc;
  logic             load;
  logic [WIDTH-1:0] load_addr;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             halted;
`ifdef PC_TRACE_EN
  logic [WIDTH-1:0] last_jump_src;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the outputs should read after each edge.
  logic [WIDTH-1:0] mPc;
  bit               mValid;
  bit               mHalted;
  logic [WIDTH-1:0] mSrc;

  program_counter16 #(.WIDTH(WIDTH), .RESET_VEC('0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .en_inc      (en_inc),
    .load        (load),
    .load_addr   (load_addr),
    .fetch_ready (fetch_ready),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .halted      (halted)
`ifdef PC_TRACE_EN
    ,
    .last_jump_src (last_jump_src)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".pc"},       32'(pc),       32'(mPc));
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(mValid));
    check({tag, ".halted"},   32'(halted),   32'(mHalted));
`ifdef PC_TRACE_EN
    check({tag, ".src"},      32'(last_jump_src), 32'(mSrc));
`endif
  endtask

  task automatic modelReset();
    mPc = '0; mValid = 0; mHalted = 0; mSrc = '0;
  endtask

  // Apply the rules to the inputs present at the coming edge.
  task automatic modelEdge();
    if (clr) begin
      mPc = '0; mValid = 0; mHalted = 0; mSrc = '0;
    end else if (mHalted) begin
      // parked: everything but clr/rst_n ignored
    end else if (!mValid) begin
      mValid = 1;  // dead cycle over
    end else if (fetch_ready) begin
      if (load) begin
        mSrc = mPc;
        if (load_addr == mPc) begin
          mHalted = 1; mValid = 0;
        end else begin
          mPc = load_addr;
        end
      end else if (en_inc) begin
        mPc = WIDTH'((int'(mPc) + 1) % (1 << WIDTH));
      end
    end
  endtask

  task automatic setIn(input bit c, input bit l, input bit e,
                       input logic [WIDTH-1:0] a, input bit r);
    clr = c; load = l; en_inc = e; load_addr = a; fetch_ready = r;
  endtask

  task automatic step(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  // Jump to an address through an accepted load (assumes RUN and target != pc).
  task automatic forcePc(input logic [WIDTH-1:0] a);
    setIn(0, 1, 0, a, 1);
    step("force");
  endtask

  initial begin
    rst_n = 1'b0;
    setIn(0, 0, 0, '0, 0);
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll("reset_release");

    // 1: dead cycle, then 0,1,2,3
    setIn(0, 0, 1, '0, 1);
    for (int i = 0; i < 4; i++) step("t1_inc");
    check("t1_final_pc", 32'(pc), 32'h3);

    // 2: stalled load holds, lands the cycle after fire
    forcePc(16'h0005);
    setIn(0, 1, 0, 16'h0100, 0);
    for (int i = 0; i < 3; i++) step("t2_stall");
    check("t2_stall_pc", 32'(pc), 32'h5);
    fetch_ready = 1;
    step("t2_fire");
    check("t2_jump_pc", 32'(pc), 32'h100);

    // 3: wrap 0xFFFF -> 0
    forcePc(16'hFFFF);
    setIn(0, 0, 1, '0, 1);
    step("t3_wrap");
    check("t3_wrap_pc", 32'(pc), 32'h0);
    check("t3_wrap_halted", 32'(halted), 32'h0);

    // 4: jump-to-self halts; HALT ignores traffic; clr restarts
    forcePc(16'h0010);
    setIn(0, 1, 0, 16'h0010, 1);
    step("t4_halt");
    check("t4_halted", 32'(halted), 32'h1);
    check("t4_valid", 32'(pc_valid), 32'h0);
    check("t4_pc", 32'(pc), 32'h10);
    setIn(0, 1, 1, 16'h0123, 1);
    step("t4_parked");
    setIn(1, 0, 0, '0, 0);
    step("t4_clr");
    check("t4_clr_pc", 32'(pc), 32'h0);
    setIn(0, 0, 0, '0, 1);
    step("t4_idle_done");
    check("t4_run_valid", 32'(pc_valid), 32'h1);

    // 5: clr beats load/en_inc with fire; async reset mid-stall
    forcePc(16'h0444);
    setIn(1, 1, 1, 16'h0777, 1);
    step("t5_clr_wins");
    check("t5_clr_pc", 32'(pc), 32'h0);
    setIn(0, 0, 0, '0, 1);
    step("t5_idle");
    forcePc(16'h0abc);
    setIn(0, 1, 0, 16'h0def, 0);
    step("t5_stall");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("t5_async_rst");
    check("t5_async_pc", 32'(pc), 32'h0);
    #1;
    rst_n = 1'b1;
    setIn(0, 0, 0, '0, 1);
    step("t5_release");

`ifdef PC_TRACE_EN
    // 6: trace records the pre-jump pc, unaffected by increments
    forcePc(16'h0020);
    setIn(0, 1, 0, 16'h0040, 1);
    step("t6_jump");
    check("t6_src", 32'(last_jump_src), 32'h20);
    setIn(0, 0, 1, '0, 1);
    step("t6_inc");
    check("t6_src_hold", 32'(last_jump_src), 32'h20);
`endif

    // Randomized traffic; occasional clr, self-jumps and near-wrap targets.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      a = mPc;
      else if (sel < 4) a = WIDTH'(16'hFFFF - $urandom_range(0, 2));
      else              a = WIDTH'($urandom);
      setIn(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1) == 1, a, ($urandom_range(0, 3) != 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
